ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/ex_muldiv.sv | 235 +++++++++++++++++++++++
 tb/tb_ex_muldiv.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// ex_muldiv: RV32/64 execute stage with operand forwarding, a combinational ALU
// and an iterative radix-2 multiply/divide unit that stalls IF/ID/EX.
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   valid_ex, Flush_ex      EX holds a real instruction / kill it
//   ALUCode_ex              ALU operation (0 add .. 10 passB)
//   IsMD_ex, MDOp_ex        M-extension instruction and its funct3
//   ALUSrcA_ex, ALUSrcB_ex  operand selects (A: rs1/PC, B: rs2/imm/4/0)
//   Imm_ex, PC_ex           immediate and instruction PC
//   rsNAddr_ex, rsNData_ex  source register numbers and register file data
//   ALUResult_mem, RegWriteData_wb, rdAddr_*, RegWrite_*  forwarding sources
//   ALUResult_ex            EX result (MD result while the FSM is in DONE)
//   MemWriteData_ex         forwarded rs2 value for stores
//   ALU_A, ALU_B            ALU operands after muxing
//   Stall_ex                freeze IF/ID/EX while an MD operation runs
//   MDBusy                  MD FSM is in BUSY or DONE
module ex_muldiv #(
    parameter int XLEN  = 32,
    parameter bit MD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_ex,
    input  logic            Flush_ex,
    input  logic [3:0]      ALUCode_ex,
    input  logic            IsMD_ex,
    input  logic [2:0]      MDOp_ex,
    input  logic            ALUSrcA_ex,
    input  logic [1:0]      ALUSrcB_ex,
    input  logic [XLEN-1:0] Imm_ex,
    input  logic [XLEN-1:0] PC_ex,
    input  logic [4:0]      rs1Addr_ex,
    input  logic [4:0]      rs2Addr_ex,
    input  logic [XLEN-1:0] rs1Data_ex,
    input  logic [XLEN-1:0] rs2Data_ex,
    input  logic [XLEN-1:0] ALUResult_mem,
    input  logic [XLEN-1:0] RegWriteData_wb,
    input  logic [4:0]      rdAddr_mem,
    input  logic [4:0]      rdAddr_wb,
    input  logic            RegWrite_mem,
    input  logic            RegWrite_wb,
    output logic [XLEN-1:0] ALUResult_ex,
    output logic [XLEN-1:0] MemWriteData_ex,
    output logic [XLEN-1:0] ALU_A,
    output logic [XLEN-1:0] ALU_B,
    output logic            Stall_ex,
    output logic            MDBusy
);

    localparam int SW = (XLEN == 64) ? 6 : 5;
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [XLEN-1:0] rs1_fwd, rs2_fwd;
    logic [3:0]      alu_code;
    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] alu_res;

    logic            md_start;
    logic            a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;

    logic [2:0]      op_q;
    logic            qneg_q, rneg_q, divz_q;
    logic [XLEN-1:0] hi_q, lo_q, b_q;
    logic [XLEN-1:0] hi_d, lo_d;
    logic [CW-1:0]   cnt_q;

    logic [XLEN:0]     mul_sum, div_shl, div_trial;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quot, rem, md_res;

    // Forwarding: MEM beats WB, x0 is never forwarded
    always_comb begin
        if (RegWrite_mem && rdAddr_mem != 5'd0 && rdAddr_mem == rs1Addr_ex)
            rs1_fwd = ALUResult_mem;
        else if (RegWrite_wb && rdAddr_wb != 5'd0 && rdAddr_wb == rs1Addr_ex)
            rs1_fwd = RegWriteData_wb;
        else
            rs1_fwd = rs1Data_ex;
    end

    always_comb begin
        if (RegWrite_mem && rdAddr_mem != 5'd0 && rdAddr_mem == rs2Addr_ex)
            rs2_fwd = ALUResult_mem;
        else if (RegWrite_wb && rdAddr_wb != 5'd0 && rdAddr_wb == rs2Addr_ex)
            rs2_fwd = RegWriteData_wb;
        else
            rs2_fwd = rs2Data_ex;
    end

    assign MemWriteData_ex = rs2_fwd;
    assign ALU_A = ALUSrcA_ex ? PC_ex : rs1_fwd;

    always_comb begin
        unique case (ALUSrcB_ex)
            2'd0:    ALU_B = rs2_fwd;
            2'd1:    ALU_B = Imm_ex;
            2'd2:    ALU_B = XLEN'(4);
            default: ALU_B = '0;
        endcase
    end

    // Without the MD unit an M instruction degrades to a plain add
    assign alu_code = (!MD_EN && IsMD_ex) ? 4'd0 : ALUCode_ex;
    assign shamt    = ALU_B[SW-1:0];

    always_comb begin
        unique case (alu_code)
            4'd0:    alu_res = ALU_A + ALU_B;
            4'd1:    alu_res = ALU_A - ALU_B;
            4'd2:    alu_res = ALU_A << shamt;
            4'd3:    alu_res = {{(XLEN-1){1'b0}}, $signed(ALU_A) < $signed(ALU_B)};
            4'd4:    alu_res = {{(XLEN-1){1'b0}}, ALU_A < ALU_B};
            4'd5:    alu_res = ALU_A ^ ALU_B;
            4'd6:    alu_res = ALU_A >> shamt;
            4'd7:    alu_res = $signed(ALU_A) >>> shamt;
            4'd8:    alu_res = ALU_A | ALU_B;
            4'd9:    alu_res = ALU_A & ALU_B;
            4'd10:   alu_res = ALU_B;
            default: alu_res = '0;
        endcase
    end

    // Operand signedness per funct3; the core works on magnitudes
    always_comb begin
        unique case (MDOp_ex)
            3'd0, 3'd1, 3'd4, 3'd6: begin a_sgn = 1'b1; b_sgn = 1'b1; end
            3'd2:                   begin a_sgn = 1'b1; b_sgn = 1'b0; end
            default:                begin a_sgn = 1'b0; b_sgn = 1'b0; end
        endcase
    end

    assign a_neg = a_sgn & rs1_fwd[XLEN-1];
    assign b_neg = b_sgn & rs2_fwd[XLEN-1];
    assign a_mag = a_neg ? -rs1_fwd : rs1_fwd;
    assign b_mag = b_neg ? -rs2_fwd : rs2_fwd;

    assign md_start = MD_EN && state_q == S_IDLE && valid_ex && IsMD_ex && !Flush_ex;

    // One iteration: multiply shifts the product right through {hi,lo};
    // divide shifts the dividend out of lo into the partial remainder hi
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
        div_shl   = {hi_q, lo_q[XLEN-1]};
        div_trial = div_shl - {1'b0, b_q};
        if (op_q[2]) begin
            if (!div_trial[XLEN]) begin
                hi_d = div_trial[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_d = div_shl[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_d = mul_sum[XLEN:1];
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q   <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            divz_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
        end else if (md_start) begin
            op_q   <= MDOp_ex;
            qneg_q <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            divz_q <= (rs2_fwd == '0);
            hi_q   <= '0;
            lo_q   <= a_mag;
            b_q    <= b_mag;
            cnt_q  <= CW'(XLEN);
        end else if (state_q == S_BUSY) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // Sign correction; a zero divisor forces an all-ones quotient while the
    // remainder naturally comes out equal to the dividend
    always_comb begin
        prod     = {hi_q, lo_q};
        prod_fix = qneg_q ? -prod : prod;
        quot     = divz_q ? '1 : (qneg_q ? -lo_q : lo_q);
        rem      = rneg_q ? -hi_q : hi_q;
        unique case (op_q)
            3'd0:             md_res = prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3: md_res = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:       md_res = quot;
            default:          md_res = rem;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (Flush_ex) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:  if (md_start) state_d = S_BUSY;
                S_BUSY:  if (cnt_q == CW'(1)) state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        Stall_ex     = !reset && !Flush_ex && (md_start || state_q == S_BUSY);
        MDBusy       = (state_q != S_IDLE);
        ALUResult_ex = (state_q == S_DONE && !Flush_ex) ? md_res : alu_res;
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed and randomized checks of ex_muldiv (XLEN=32 and 64)
// against a plain-arithmetic reference model.
module tb_ex_muldiv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        valid_ex, Flush_ex, IsMD_ex, ALUSrcA_ex;
    logic [3:0]  ALUCode_ex;
    logic [2:0]  MDOp_ex;
    logic [1:0]  ALUSrcB_ex;
    logic [31:0] Imm_ex, PC_ex, rs1Data_ex, rs2Data_ex;
    logic [31:0] ALUResult_mem, RegWriteData_wb;
    logic [4:0]  rs1Addr_ex, rs2Addr_ex, rdAddr_mem, rdAddr_wb;
    logic        RegWrite_mem, RegWrite_wb;
    logic [31:0] ALUResult_ex, MemWriteData_ex, ALU_A, ALU_B;
    logic        Stall_ex, MDBusy;

    logic        w_valid, w_ismd;
    logic [2:0]  w_op;
    logic [63:0] w_rs1, w_rs2;
    logic [63:0] w_res, w_mwd, w_a, w_b;
    logic        w_stall, w_busy;

    int errors = 0;
    int checks = 0;

    ex_muldiv #(.XLEN(32), .MD_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .valid_ex(valid_ex), .Flush_ex(Flush_ex),
        .ALUCode_ex(ALUCode_ex), .IsMD_ex(IsMD_ex), .MDOp_ex(MDOp_ex),
        .ALUSrcA_ex(ALUSrcA_ex), .ALUSrcB_ex(ALUSrcB_ex), .Imm_ex(Imm_ex),
        .PC_ex(PC_ex), .rs1Addr_ex(rs1Addr_ex), .rs2Addr_ex(rs2Addr_ex),
        .rs1Data_ex(rs1Data_ex), .rs2Data_ex(rs2Data_ex),
        .ALUResult_mem(ALUResult_mem), .RegWriteData_wb(RegWriteData_wb),
        .rdAddr_mem(rdAddr_mem), .rdAddr_wb(rdAddr_wb),
        .RegWrite_mem(RegWrite_mem), .RegWrite_wb(RegWrite_wb),
        .ALUResult_ex(ALUResult_ex), .MemWriteData_ex(MemWriteData_ex),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .Stall_ex(Stall_ex), .MDBusy(MDBusy)
    );

    ex_muldiv #(.XLEN(64), .MD_EN(1'b1)) dut64 (
        .clk(clk), .reset(reset), .valid_ex(w_valid), .Flush_ex(1'b0),
        .ALUCode_ex(4'd0), .IsMD_ex(w_ismd), .MDOp_ex(w_op),
        .ALUSrcA_ex(1'b0), .ALUSrcB_ex(2'd0), .Imm_ex(64'd0),
        .PC_ex(64'd0), .rs1Addr_ex(5'd1), .rs2Addr_ex(5'd2),
        .rs1Data_ex(w_rs1), .rs2Data_ex(w_rs2),
        .ALUResult_mem(64'd0), .RegWriteData_wb(64'd0),
        .rdAddr_mem(5'd0), .rdAddr_wb(5'd0),
        .RegWrite_mem(1'b0), .RegWrite_wb(1'b0),
        .ALUResult_ex(w_res), .MemWriteData_ex(w_mwd),
        .ALU_A(w_a), .ALU_B(w_b), .Stall_ex(w_stall), .MDBusy(w_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: RISC-V M semantics from wide signed/unsigned arithmetic
    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [63:0] a,
                                           input logic [63:0] b, input int w);
        logic [63:0] m, mn, aa, bb;
        logic signed [129:0] as, bs, au, bu, p;
        m  = (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        mn = 64'd1 << (w - 1);
        aa = a & m;
        bb = b & m;
        au = {66'd0, aa};
        bu = {66'd0, bb};
        as = au;
        bs = bu;
        if ((aa & mn) != 0) as = au - (130'sd1 <<< w);
        if ((bb & mn) != 0) bs = bu - (130'sd1 <<< w);
        p = '0;
        case (op)
            3'd0: p = as * bs;
            3'd1: p = (as * bs) >>> w;
            3'd2: p = (as * bu) >>> w;
            3'd3: p = (au * bu) >>> w;
            3'd4: begin
                if (bb == 0) return m;
                if (aa == mn && bb == m) return mn;
                p = as / bs;
            end
            3'd5: begin
                if (bb == 0) return m;
                p = au / bu;
            end
            3'd6: begin
                if (bb == 0) return aa;
                if (aa == mn && bb == m) return 64'd0;
                p = as % bs;
            end
            default: begin
                if (bb == 0) return aa;
                p = au % bu;
            end
        endcase
        return p[63:0] & m;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (c)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a << sh;
            4'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4:  return (a < b) ? 32'd1 : 32'd0;
            4'd5:  return a ^ b;
            4'd6:  return a >> sh;
            4'd7:  return 32'($signed(a) >>> sh);
            4'd8:  return a | b;
            4'd9:  return a & b;
            4'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] ad, input logic [31:0] rf);
        if (RegWrite_mem && rdAddr_mem != 0 && rdAddr_mem == ad) return ALUResult_mem;
        if (RegWrite_wb && rdAddr_wb != 0 && rdAddr_wb == ad) return RegWriteData_wb;
        return rf;
    endfunction

    function automatic logic [31:0] exp_a();
        return ALUSrcA_ex ? PC_ex : fwd(rs1Addr_ex, rs1Data_ex);
    endfunction

    function automatic logic [31:0] exp_b();
        case (ALUSrcB_ex)
            2'd0: return fwd(rs2Addr_ex, rs2Data_ex);
            2'd1: return Imm_ex;
            2'd2: return 32'd4;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Runs one MD op; operands come via forwarding when fw=1, and all
    // forwarding/register inputs are scrambled while the unit is busy
    task automatic do_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit fw, output logic [31:0] res);
        int n;
        Flush_ex   = 1'b0;
        valid_ex   = 1'b1;
        IsMD_ex    = 1'b1;
        MDOp_ex    = op;
        ALUCode_ex = 4'($urandom_range(0, 15));
        rs1Addr_ex = 5'd7;
        rs2Addr_ex = 5'd8;
        if (fw) begin
            RegWrite_mem = 1'b1; rdAddr_mem = 5'd7; ALUResult_mem = a;
            RegWrite_wb = 1'b1; rdAddr_wb = 5'd8; RegWriteData_wb = b;
            rs1Data_ex = $urandom; rs2Data_ex = $urandom;
        end else begin
            RegWrite_mem = 1'b0; RegWrite_wb = 1'b0;
            rs1Data_ex = a; rs2Data_ex = b;
        end
        #1;
        chk("md_start_stall", 64'(Stall_ex), 64'd1);
        n = 0;
        while (Stall_ex === 1'b1 && n < 200) begin
            n++;
            tick;
            ALUResult_mem   = $urandom;
            RegWriteData_wb = $urandom;
            rs1Data_ex      = $urandom;
            rs2Data_ex      = $urandom;
            #1;
        end
        chk("md_latency", 64'(n), 64'd33);
        res = ALUResult_ex;
        chk("md_result", 64'(res), ref_md(op, 64'(a), 64'(b), 32));
        chk("md_busy_done", 64'(MDBusy), 64'd1);
        valid_ex = 1'b0;
        IsMD_ex  = 1'b0;
        tick;
        chk("md_back_idle", 64'(MDBusy), 64'd0);
        chk("md_alu_after", 64'(ALUResult_ex), 64'(ref_alu(ALUCode_ex, exp_a(), exp_b())));
        RegWrite_mem = 1'b0;
        RegWrite_wb  = 1'b0;
    endtask

    task automatic do_md64(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        int n;
        w_valid = 1'b1;
        w_ismd  = 1'b1;
        w_op    = op;
        w_rs1   = a;
        w_rs2   = b;
        #1;
        n = 0;
        while (w_stall === 1'b1 && n < 300) begin
            n++;
            tick;
        end
        chk("md64_latency", 64'(n), 64'd65);
        chk("md64_result", w_res, ref_md(op, a, b, 64));
        w_valid = 1'b0;
        w_ismd  = 1'b0;
        tick;
        chk("md64_idle", 64'(w_busy), 64'd0);
    endtask

    task automatic start_div(input logic [31:0] a, input logic [31:0] b);
        Flush_ex = 1'b0; valid_ex = 1'b1; IsMD_ex = 1'b1; MDOp_ex = 3'd4;
        RegWrite_mem = 1'b0; RegWrite_wb = 1'b0;
        rs1Data_ex = a; rs2Data_ex = b;
    endtask

    initial begin
        logic [31:0] r;
        int seen;

        reset = 1'b1;
        valid_ex = 1'b1; IsMD_ex = 1'b1; Flush_ex = 1'b0;
        ALUCode_ex = 4'd0; MDOp_ex = 3'd0; ALUSrcA_ex = 1'b0; ALUSrcB_ex = 2'd0;
        Imm_ex = '0; PC_ex = '0; rs1Data_ex = 32'd3; rs2Data_ex = 32'd4;
        ALUResult_mem = '0; RegWriteData_wb = '0;
        rs1Addr_ex = 5'd1; rs2Addr_ex = 5'd2; rdAddr_mem = '0; rdAddr_wb = '0;
        RegWrite_mem = 1'b0; RegWrite_wb = 1'b0;
        w_valid = 1'b0; w_ismd = 1'b0; w_op = '0; w_rs1 = '0; w_rs2 = '0;

        #2;
        chk("rst_stall", 64'(Stall_ex), 64'd0);
        chk("rst_busy", 64'(MDBusy), 64'd0);
        tick;
        tick;
        chk("rst_stall_held", 64'(Stall_ex), 64'd0);
        valid_ex = 1'b0; IsMD_ex = 1'b0;
        reset = 1'b0;
        tick;
        chk("idle_busy", 64'(MDBusy), 64'd0);
        chk("idle_alu", 64'(ALUResult_ex), 64'd7);

        // Forwarding priorities
        rs1Addr_ex = 5'd5; rdAddr_mem = 5'd5; rdAddr_wb = 5'd5;
        RegWrite_mem = 1'b1; RegWrite_wb = 1'b1;
        ALUResult_mem = 32'h11; RegWriteData_wb = 32'h22; rs1Data_ex = 32'h33;
        ALUCode_ex = 4'd0; ALUSrcA_ex = 1'b0; ALUSrcB_ex = 2'd1; Imm_ex = 32'd1;
        rs2Addr_ex = 5'd5; rs2Data_ex = 32'h44;
        #1;
        chk("fwd_mem", 64'(ALUResult_ex), 64'h12);
        chk("fwd_mem_store", 64'(MemWriteData_ex), 64'h11);
        rdAddr_mem = 5'd6;
        #1;
        chk("fwd_wb", 64'(ALUResult_ex), 64'h23);
        rdAddr_mem = 5'd0; rdAddr_wb = 5'd0;
        #1;
        chk("fwd_x0", 64'(ALUResult_ex), 64'h34);
        chk("fwd_x0_store", 64'(MemWriteData_ex), 64'h44);
        tick;

        // Randomized ALU / operand muxing
        for (int i = 0; i < 40; i++) begin
            valid_ex = 1'b1; IsMD_ex = 1'b0; Flush_ex = 1'b0;
            ALUCode_ex = 4'($urandom_range(0, 15));
            ALUSrcA_ex = 1'($urandom_range(0, 1));
            ALUSrcB_ex = 2'($urandom_range(0, 3));
            Imm_ex = $urandom; PC_ex = $urandom;
            rs1Data_ex = pick(); rs2Data_ex = pick();
            ALUResult_mem = pick(); RegWriteData_wb = $urandom;
            rs1Addr_ex = 5'($urandom_range(0, 3)); rs2Addr_ex = 5'($urandom_range(0, 3));
            rdAddr_mem = 5'($urandom_range(0, 3)); rdAddr_wb = 5'($urandom_range(0, 3));
            RegWrite_mem = 1'($urandom_range(0, 1)); RegWrite_wb = 1'($urandom_range(0, 1));
            #2;
            chk("alu_a", 64'(ALU_A), 64'(exp_a()));
            chk("alu_b", 64'(ALU_B), 64'(exp_b()));
            chk("store_data", 64'(MemWriteData_ex), 64'(fwd(rs2Addr_ex, rs2Data_ex)));
            chk("alu_result", 64'(ALUResult_ex), 64'(ref_alu(ALUCode_ex, exp_a(), exp_b())));
        end
        valid_ex = 1'b0; RegWrite_mem = 1'b0; RegWrite_wb = 1'b0;
        ALUSrcA_ex = 1'b0; ALUSrcB_ex = 2'd0;
        tick;

        // Directed MD cases
        do_md(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, r);
        chk("div_m7_2", 64'(r), 64'hFFFF_FFFD);
        do_md(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0, r);
        chk("rem_m7_2", 64'(r), 64'hFFFF_FFFF);
        do_md(3'd5, 32'd5, 32'd0, 1'b0, r);
        chk("divu_by0", 64'(r), 64'hFFFF_FFFF);
        do_md(3'd7, 32'd5, 32'd0, 1'b0, r);
        chk("remu_by0", 64'(r), 64'd5);
        do_md(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, r);
        chk("div_ovf", 64'(r), 64'h8000_0000);
        do_md(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, r);
        chk("rem_ovf", 64'(r), 64'd0);
        do_md(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, r);
        chk("mulh_min", 64'(r), 64'h4000_0000);
        do_md(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, r);
        chk("mulhu_max", 64'(r), 64'hFFFF_FFFE);
        do_md(3'd4, 32'hFFFF_FFF9, 32'd0, 1'b0, r);
        chk("div_s_by0", 64'(r), 64'hFFFF_FFFF);

        // Operands via forwarding, sources change during BUSY
        do_md(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, r);
        do_md(3'd2, 32'hF000_0001, 32'hFFFF_FFFF, 1'b1, r);

        // Randomized MD
        for (int i = 0; i < 16; i++)
            do_md(3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)), r);

        // Reset in the middle of BUSY
        start_div(32'd1000, 32'd7);
        #1;
        for (int i = 0; i < 10; i++) tick;
        reset = 1'b1;
        #1;
        chk("rst_mid_stall", 64'(Stall_ex), 64'd0);
        chk("rst_mid_busy", 64'(MDBusy), 64'd0);
        tick;
        valid_ex = 1'b0; IsMD_ex = 1'b0;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (MDBusy !== 1'b0) seen++;
        end
        chk("rst_no_done", 64'(seen), 64'd0);

        // Flush at BUSY cycle 5
        start_div(32'd1000, 32'd7);
        #1;
        for (int i = 0; i < 5; i++) tick;
        chk("flush_pre_busy", 64'(MDBusy), 64'd1);
        Flush_ex = 1'b1;
        #1;
        chk("flush_stall", 64'(Stall_ex), 64'd0);
        tick;
        chk("flush_idle", 64'(MDBusy), 64'd0);
        Flush_ex = 1'b0; valid_ex = 1'b0; IsMD_ex = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (MDBusy !== 1'b0) seen++;
        end
        chk("flush_no_done", 64'(seen), 64'd0);

        // 64-bit instance
        w_rs1 = {$urandom, $urandom};
        w_rs2 = {$urandom, $urandom};
        #1;
        chk("w_alu_add", w_res, w_rs1 + w_rs2);
        chk("w_store", w_mwd, w_rs2);
        chk("w_ops", w_a ^ w_b, w_rs1 ^ w_rs2);
        tick;
        do_md64(3'd0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7);
        do_md64(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        do_md64(3'd1, {$urandom, $urandom}, {$urandom, $urandom});
        do_md64(3'd4, {$urandom, $urandom}, {32'd0, $urandom});
        do_md64(3'd6, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
